// File: rtl/ysyx_25030093_lsu_pkg.sv
// Shared definitions for the LSU bus initiator and its load extractor.
// Holds the FSM state encoding, access-size encodings and the write-strobe
// encoding helper used on the AW/W channel.
package ysyx_25030093_lsu_pkg;

  localparam int unsigned SZ_W   = 2;
  localparam int unsigned STRB_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } lsu_state_e;

  localparam logic [SZ_W-1:0] SIZE_B = 2'd0;
  localparam logic [SZ_W-1:0] SIZE_H = 2'd1;
  localparam logic [SZ_W-1:0] SIZE_W = 2'd2;

  // The SRAM responder takes the access size on wstrb, not a byte mask.
  function automatic logic [STRB_W-1:0] wstrb_enc(input logic [SZ_W-1:0] size);
    return {1'b0, size};
  endfunction

  // Half needs addr[0]==0, word needs addr[1:0]==0, size 3 is never legal.
  function automatic logic is_misaligned(input logic [SZ_W-1:0] size,
                                         input logic [1:0]      addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_ext.sv
// Combinational load-data extractor: selects the byte/half lane from a
// word-aligned read beat and sign- or zero-extends it to DATA_W bits.
// Ports: rdata (raw bus word), addr_lo (byte offset), size, is_unsigned,
//        result (extended load value).
module ysyx_25030093_lsu_ext
  import ysyx_25030093_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [SZ_W-1:0]   size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection from the word-aligned beat.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by size and signedness; words and illegal sizes pass through.
  always_comb begin
    result = rdata;
    case (size)
      SIZE_B: result = is_unsigned ? {{(DATA_W-8){1'b0}}, byte_sel}
                                   : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      SIZE_H: result = is_unsigned ? {{(DATA_W-16){1'b0}}, half_sel}
                                   : {{(DATA_W-16){half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_lsu_axi_master.sv
// LSU bus initiator: takes one load/store request at a time from the memory
// stage, runs it on the AR/R or AW/W/B channel and returns a one-cycle
// response with extended load data or a misalignment flag.
// Ports: req_* (core request, req_ready high only when idle),
//        resp_* (completion pulse, load data, misalign flag),
//        LSU_ar*/LSU_r* (read channel), LSU_aw*/LSU_w*/LSU_b* (write channel).
// All outputs are registered; each output's next value is derived from the
// next state so it lines up with the state it belongs to.
module ysyx_25030093_lsu_axi_master
  import ysyx_25030093_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SZ_W-1:0]   req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,

  output logic [ADDR_W-1:0] LSU_araddr,
  output logic              LSU_arvalid,
  input  logic              LSU_arready,
  input  logic [DATA_W-1:0] LSU_rdata,
  input  logic              LSU_rvalid,
  output logic              LSU_rready,
  output logic [ADDR_W-1:0] LSU_awaddr,
  output logic              LSU_awvalid,
  input  logic              LSU_awready,
  output logic [DATA_W-1:0] LSU_wdata,
  output logic [STRB_W-1:0] LSU_wstrb,
  output logic              LSU_wvalid,
  input  logic              LSU_wready,
  input  logic              LSU_bvalid,
  output logic              LSU_bready
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [SZ_W-1:0]   size_q, size_d;
  logic              uns_q, uns_d;

  logic              req_ready_d, resp_valid_d, resp_misalign_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic [ADDR_W-1:0] araddr_d, awaddr_d;
  logic              arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic [DATA_W-1:0] wdata_d;
  logic [STRB_W-1:0] wstrb_d;

  logic [DATA_W-1:0] ext_data;
  logic              req_mis;
  logic              aw_done, w_done;

  // Load lane extraction on the live read beat, using the latched request.
  ysyx_25030093_lsu_ext #(.DATA_W(DATA_W)) u_ext (
    .rdata       (LSU_rdata),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_data)
  );

  assign req_mis = is_misaligned(req_size, req_addr[1:0]);
  // A write sub-channel is done once its valid has dropped or fires now.
  assign aw_done = !LSU_awvalid || LSU_awready;
  assign w_done  = !LSU_wvalid  || LSU_wready;

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    addr_lo_d       = addr_lo_q;
    size_d          = size_q;
    uns_d           = uns_q;
    resp_rdata_d    = resp_rdata;
    resp_misalign_d = resp_misalign;
    araddr_d        = LSU_araddr;
    arvalid_d       = LSU_arvalid;
    rready_d        = LSU_rready;
    awaddr_d        = LSU_awaddr;
    awvalid_d       = LSU_awvalid;
    wdata_d         = LSU_wdata;
    wstrb_d         = LSU_wstrb;
    wvalid_d        = LSU_wvalid;
    bready_d        = LSU_bready;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_lo_d       = req_addr[1:0];
          size_d          = req_size;
          uns_d           = req_unsigned;
          resp_rdata_d    = '0;
          resp_misalign_d = req_mis;
          if (req_mis) begin
            state_d = ST_RESP;
          end else if (req_wen) begin
            state_d   = ST_WR_REQ;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = wstrb_enc(req_size);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
          end else begin
            state_d   = ST_RD_ADDR;
            araddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            arvalid_d = 1'b1;
            // The responder only accepts AR while rready is also high.
            rready_d  = 1'b1;
          end
        end
      end
      ST_RD_ADDR: begin
        if (LSU_arvalid && LSU_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (LSU_rvalid) begin
          rready_d     = 1'b0;
          resp_rdata_d = ext_data;
          state_d      = ST_RESP;
        end
      end
      ST_WR_REQ: begin
        if (LSU_awvalid && LSU_awready) awvalid_d = 1'b0;
        if (LSU_wvalid && LSU_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done)          state_d   = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (LSU_bvalid) begin
          bready_d = 1'b0;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_lo_q     <= 2'b00;
      size_q        <= SIZE_B;
      uns_q         <= 1'b0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      LSU_araddr    <= '0;
      LSU_arvalid   <= 1'b0;
      LSU_rready    <= 1'b0;
      LSU_awaddr    <= '0;
      LSU_awvalid   <= 1'b0;
      LSU_wdata     <= '0;
      LSU_wstrb     <= '0;
      LSU_wvalid    <= 1'b0;
      LSU_bready    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_lo_q     <= addr_lo_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      req_ready     <= req_ready_d;
      resp_valid    <= resp_valid_d;
      resp_rdata    <= resp_rdata_d;
      resp_misalign <= resp_misalign_d;
      LSU_araddr    <= araddr_d;
      LSU_arvalid   <= arvalid_d;
      LSU_rready    <= rready_d;
      LSU_awaddr    <= awaddr_d;
      LSU_awvalid   <= awvalid_d;
      LSU_wdata     <= wdata_d;
      LSU_wstrb     <= wstrb_d;
      LSU_wvalid    <= wvalid_d;
      LSU_bready    <= bready_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu_axi_master.sv
// Scoreboard bench for the LSU bus initiator with a small SRAM responder
// model (zero-wait by default, optional awready stall).
module tb_ysyx_25030093_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_misalign;
  logic [31:0] resp_rdata;
  logic [31:0] LSU_araddr, LSU_rdata, LSU_awaddr, LSU_wdata;
  logic        LSU_arvalid, LSU_arready, LSU_rvalid, LSU_rready;
  logic        LSU_awvalid, LSU_awready, LSU_wvalid, LSU_wready;
  logic [2:0]  LSU_wstrb;
  logic        LSU_bvalid, LSU_bready;

  always #5 clk = ~clk;

  ysyx_25030093_lsu_axi_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .LSU_araddr(LSU_araddr), .LSU_arvalid(LSU_arvalid), .LSU_arready(LSU_arready),
    .LSU_rdata(LSU_rdata), .LSU_rvalid(LSU_rvalid), .LSU_rready(LSU_rready),
    .LSU_awaddr(LSU_awaddr), .LSU_awvalid(LSU_awvalid), .LSU_awready(LSU_awready),
    .LSU_wdata(LSU_wdata), .LSU_wstrb(LSU_wstrb), .LSU_wvalid(LSU_wvalid),
    .LSU_wready(LSU_wready), .LSU_bvalid(LSU_bvalid), .LSU_bready(LSU_bready)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder model.
  logic [31:0] mem_rdata = 32'h0;
  int          aw_stall  = 0;
  int          aw_cnt;
  logic        rd_pend, b_pend, aw_got, w_got;

  assign LSU_arready = LSU_arvalid && LSU_rready;
  assign LSU_rvalid  = rd_pend;
  assign LSU_rdata   = rd_pend ? mem_rdata : 32'h0;
  assign LSU_awready = LSU_awvalid && (aw_cnt >= aw_stall);
  assign LSU_wready  = LSU_wvalid;
  assign LSU_bvalid  = b_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
    end else begin
      if (LSU_arvalid && LSU_arready) rd_pend <= 1'b1;
      else if (rd_pend && LSU_rready) rd_pend <= 1'b0;
      if (LSU_awvalid && LSU_awready) aw_cnt <= 0;
      else if (LSU_awvalid)           aw_cnt <= aw_cnt + 1;
      if (b_pend && LSU_bready) b_pend <= 1'b0;
      if ((aw_got || (LSU_awvalid && LSU_awready)) && (w_got || (LSU_wvalid && LSU_wready))) begin
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (LSU_awvalid && LSU_awready) aw_got <= 1'b1;
        if (LSU_wvalid && LSU_wready)   w_got  <= 1'b1;
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          exp_cyc;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] arq[$];
  logic [31:0] awq[$];
  logic [2:0]  strbq[$];
  logic [31:0] wq[$];
  int          bus_valid_cycles = 0;
  int          aw_fires = 0, w_fires = 0, b_fires = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a bus handshake.
  always @(negedge clk) begin : mon
    resp_t e;
    if (rst_n) begin
      if (resp_valid) begin
        if (sb.size() == 0) flag("unexpected_resp_valid");
        else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_misalign", 32'(resp_misalign), 32'(e.mis));
          chk("resp_cycle", 32'(cyc), 32'(e.exp_cyc));
        end
      end
      if (LSU_arvalid || LSU_awvalid || LSU_wvalid) bus_valid_cycles++;
      if (LSU_arvalid && LSU_arready) begin
        if (arq.size() == 0) flag("unexpected_ar");
        else chk("araddr", LSU_araddr, arq.pop_front());
      end
      if (LSU_awvalid && LSU_awready) begin
        aw_fires++;
        if (awq.size() == 0) flag("unexpected_aw");
        else begin
          chk("awaddr", LSU_awaddr, awq.pop_front());
          chk("wstrb", 32'(LSU_wstrb), 32'(strbq.pop_front()));
        end
      end
      if (LSU_wvalid && LSU_wready) begin
        w_fires++;
        if (wq.size() == 0) flag("unexpected_w");
        else chk("wdata", LSU_wdata, wq.pop_front());
      end
      if (LSU_bvalid && LSU_bready) b_fires++;
    end
  end

  // Issue one request; pushes hand-computed expectations after acceptance.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_mis, input int lat,
                       input logic [31:0] exp_baddr, input logic [2:0] exp_strb,
                       output int acc);
    int waited;
    resp_t e;
    waited = 0;
    acc = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      flag("req_ready_timeout");
      return;
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;
    e.rdata = exp_rdata; e.mis = exp_mis; e.exp_cyc = acc + lat - 1;
    sb.push_back(e);
    if (!exp_mis) begin
      if (wen) begin
        awq.push_back(exp_baddr); strbq.push_back(exp_strb); wq.push_back(wdata);
      end else begin
        arq.push_back(exp_baddr);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      flag("drain_timeout");
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready), 32'h1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_misalign"},   32'(resp_misalign), 32'h0);
    chk({tag, "_arvalid"},    32'(LSU_arvalid), 32'h0);
    chk({tag, "_rready"},     32'(LSU_rready), 32'h0);
    chk({tag, "_araddr"},     LSU_araddr, 32'h0);
    chk({tag, "_awvalid"},    32'(LSU_awvalid), 32'h0);
    chk({tag, "_wvalid"},     32'(LSU_wvalid), 32'h0);
    chk({tag, "_bready"},     32'(LSU_bready), 32'h0);
    chk({tag, "_awaddr"},     LSU_awaddr, 32'h0);
    chk({tag, "_wdata"},      LSU_wdata, 32'h0);
    chk({tag, "_wstrb"},      32'(LSU_wstrb), 32'h0);
  endtask

  initial begin
    int a1, a2, av0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0;
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Word load, zero-wait: response in cycle 3.
    mem_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, 32'h8000_0004, 3'd0, a1);
    drain();

    // Signed then unsigned byte load back-to-back; 4-cycle request period.
    mem_rdata = 32'h80FF_0000;
    issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0, 3, 32'h8000_0000, 3'd0, a1);
    issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h0000_0080, 1'b0, 3, 32'h8000_0000, 3'd0, a2);
    chk("b2b_period", 32'(a2 - a1), 32'd4);
    drain();

    // Half loads: signed upper lane, unsigned lower lane; byte lane 1.
    mem_rdata = 32'h8001_7FFF;
    issue(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'hFFFF_8001, 1'b0, 3, 32'h8000_0000, 3'd0, a1);
    drain();
    mem_rdata = 32'h8001_F00F;
    issue(1'b0, 32'h8000_0000, 32'h0, 2'd1, 1'b1, 32'h0000_F00F, 1'b0, 3, 32'h8000_0000, 3'd0, a1);
    drain();
    mem_rdata = 32'h0000_7F00;
    issue(1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 32'h0000_007F, 1'b0, 3, 32'h8000_0000, 3'd0, a1);
    drain();

    // Half store, zero-wait: full address, strobe = size, data unshifted.
    issue(1'b1, 32'h8000_0002, 32'hABCD_1234, 2'd1, 1'b0, 32'h0, 1'b0, 3, 32'h8000_0002, 3'b001, a1);
    drain();

    // Word store with awready low for 3 cycles.
    aw_stall = 3;
    issue(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b0, 6, 32'h8000_0010, 3'b010, a1);
    @(negedge clk);
    chk("stall_c1_wvalid", 32'(LSU_wvalid), 32'h1);
    chk("stall_c1_awvalid", 32'(LSU_awvalid), 32'h1);
    @(negedge clk);
    chk("stall_c2_wvalid", 32'(LSU_wvalid), 32'h0);
    chk("stall_c2_awvalid", 32'(LSU_awvalid), 32'h1);
    chk("stall_c2_awaddr", LSU_awaddr, 32'h8000_0010);
    drain();
    aw_stall = 0;

    // Misaligned requests: response next cycle, no bus valid at all.
    av0 = bus_valid_cycles;
    issue(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 1, 32'h0, 3'd0, a1);
    drain();
    issue(1'b0, 32'h8000_0001, 32'h0, 2'd1, 1'b1, 32'h0, 1'b1, 1, 32'h0, 3'd0, a1);
    drain();
    issue(1'b1, 32'h8000_0000, 32'h5555_5555, 2'd3, 1'b0, 32'h0, 1'b1, 1, 32'h0, 3'd0, a1);
    drain();
    chk("misalign_no_bus", 32'(bus_valid_cycles), 32'(av0));

    // Reset during RD_DATA abandons the load without a response.
    mem_rdata = 32'h1111_2222;
    issue(1'b0, 32'h8000_000C, 32'h0, 2'd2, 1'b0, 32'h1111_2222, 1'b0, 3, 32'h8000_000C, 3'd0, a1);
    @(posedge clk);
    #2;
    chk("pre_rst_rready", 32'(LSU_rready), 32'h1);
    chk("pre_rst_arvalid", 32'(LSU_arvalid), 32'h0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_vals("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Normal load after the abandoned one.
    mem_rdata = 32'h1234_5678;
    issue(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 3, 32'h8000_0008, 3'd0, a1);
    drain();

    repeat (3) @(negedge clk);
    chk("aw_fire_count", 32'(aw_fires), 32'd2);
    chk("w_fire_count", 32'(w_fires), 32'd2);
    chk("b_fire_count", 32'(b_fires), 32'd2);
    chk("arq_empty", 32'(arq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
